// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: reset/NOP values, fetch state encoding, opcodes.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Major opcodes, shared with the immediate generator and decoder
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  // Instruction fetch is always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding buffer used while decode is stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Occupancy flag; clear (flush) dominates, load and unload never coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Payload is only meaningful while full, so it carries no reset
  always_ff @(posedge clk) begin
    if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, single-outstanding imem request, IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4
);

  import rv32i_pkg::*;

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         accept;
  logic         rsp_live;
  logic         outstanding;
  logic         if_id_open;
  logic         skid_full;
  logic         skid_load;
  logic         skid_unload;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  // Request is held high until granted; suppressed while the skid is occupied
  assign imem_req  = !rst && (state == FETCH) && !skid_full;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // Only a response in WAIT is real; a same-cycle redirect makes it stale
  assign rsp_live    = imem_rvalid && (state == WAIT) && !redirect_valid;
  assign outstanding = ((state == FETCH) && accept) ||
                       (((state == WAIT) || (state == DISCARD)) && !imem_rvalid);

  // IF/ID can take a new entry when it is empty or decode is consuming
  assign if_id_open  = !if_id_valid || !stall;
  assign skid_load   = rsp_live && !if_id_open;
  assign skid_unload = !redirect_valid && if_id_open && skid_full;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (redirect_valid),
    .load_instr (imem_rdata),
    .load_pc    (req_addr),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a redirect decides between DISCARD and FETCH on its own
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (accept)      state_nxt = WAIT;
      WAIT:    if (imem_rvalid) state_nxt = FETCH;
      DISCARD: if (imem_rvalid) state_nxt = FETCH;
      default:                  state_nxt = FETCH;
    endcase
    if (redirect_valid) begin
      state_nxt = outstanding ? DISCARD : FETCH;
    end
  end

  // Program counter: redirect target wins over sequential advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
    end else if (accept) begin
      pc <= pc + 32'd4;
    end
  end

  // Address of the in-flight request, tagged onto its response
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= pc;
    end
  end

  // IF/ID register: flush, then hold under stall, then skid, then response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 32'd0;
      if_id_pc4   <= 32'd4;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (if_id_open) begin
      if (skid_full) begin
        if_id_valid <= 1'b1;
        if_id_instr <= skid_instr;
        if_id_pc    <= skid_pc;
        if_id_pc4   <= skid_pc + 32'd4;
      end else if (rsp_live) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem_rdata;
        if_id_pc    <= req_addr;
        if_id_pc4   <= req_addr + 32'd4;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one task per scenario, inline checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", if_id_instr, NOP); end
    checks++; if (if_id_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_id_pc); end
    checks++; if (if_id_pc4 !== 32'd4) begin errors++; $display("FAIL reset_pc4: got %h want 4", if_id_pc4); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
  endtask

  task automatic test_basic_fetch();
    imem_ready = 1'b1;
    step();  // grant addr 0
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'd4) begin errors++; $display("FAIL addr_after_grant0: got %h want 4", imem_addr); end
    step();  // response captured
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h want 00500093", if_id_instr); end
    checks++; if (if_id_pc !== 32'd0) begin errors++; $display("FAIL basic_pc: got %h want 0", if_id_pc); end
    checks++; if (if_id_pc4 !== 32'd4) begin errors++; $display("FAIL basic_pc4: got %h want 4", if_id_pc4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL basic_req2: got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
    step();  // grant addr 4
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00a0_0113;
    step();
    imem_rvalid = 1'b0;
    checks++; if (if_id_instr !== 32'h00a0_0113 || if_id_pc !== 32'd4 || if_id_pc4 !== 32'd8) begin
      errors++; $display("FAIL basic_second: got instr=%h pc=%h pc4=%h want 00a00113/4/8", if_id_instr, if_id_pc, if_id_pc4);
    end
    checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL basic_addr8: got %h want 8", imem_addr); end
  endtask

  task automatic test_ready_hold();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin
        errors++; $display("FAIL hold_req_%0d: got req=%b addr=%h want req=1 addr=8", i, imem_req, imem_addr);
      end
    end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      errors++; $display("FAIL drain_bubble: got valid=%b instr=%h want 0/%h", if_id_valid, if_id_instr, NOP);
    end
    imem_ready = 1'b1;
    step();  // grant addr 8
    imem_ready = 1'b0;
    checks++; if (imem_addr !== 32'd12 || imem_req !== 1'b0) begin
      errors++; $display("FAIL hold_grant: got req=%b addr=%h want req=0 addr=c", imem_req, imem_addr);
    end
  endtask

  task automatic test_stall_skid();
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0193;
    step();  // A into IF/ID
    imem_rvalid = 1'b0; stall = 1'b1; imem_ready = 1'b1;
    step();  // grant addr 12, IF/ID held
    imem_ready = 1'b0;
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0010_0193 || if_id_pc !== 32'd8) begin
      errors++; $display("FAIL stall_hold: got valid=%b instr=%h pc=%h want 1/00100193/8", if_id_valid, if_id_instr, if_id_pc);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_0213;
    step();  // B goes to skid
    imem_rvalid = 1'b0;
    checks++; if (if_id_instr !== 32'h0010_0193 || if_id_pc !== 32'd8) begin
      errors++; $display("FAIL skid_hold: got instr=%h pc=%h want 00100193/8", if_id_instr, if_id_pc);
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_req: got %b want 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b0 || if_id_instr !== 32'h0010_0193) begin
      errors++; $display("FAIL skid_hold2: got req=%b instr=%h want 0/00100193", imem_req, if_id_instr);
    end
    stall = 1'b0;
    step();  // skid drains into IF/ID
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0020_0213 || if_id_pc !== 32'd12 || if_id_pc4 !== 32'd16) begin
      errors++; $display("FAIL skid_unload: got valid=%b instr=%h pc=%h pc4=%h want 1/00200213/c/10", if_id_valid, if_id_instr, if_id_pc, if_id_pc4);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin
      errors++; $display("FAIL skid_resume: got req=%b addr=%h want 1/10", imem_req, imem_addr);
    end
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL skid_bubble: got %b want 0", if_id_valid); end
  endtask

  task automatic test_redirect_wait();
    imem_ready = 1'b1;
    step();  // grant addr 16
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      errors++; $display("FAIL redir_flush: got valid=%b instr=%h want 0/%h", if_id_valid, if_id_instr, NOP);
    end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_discard: got req=%b addr=%h want 0/100", imem_req, imem_addr);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    step();  // stale response dropped
    imem_rvalid = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      errors++; $display("FAIL stale_drop: got valid=%b instr=%h want 0/%h", if_id_valid, if_id_instr, NOP);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_refetch: got req=%b addr=%h want 1/100", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    imem_ready = 1'b1;
    step();  // grant 0x100
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0030_8293;
    step();
    imem_rvalid = 1'b0;
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h0030_8293) begin
      errors++; $display("FAIL redir_target_fetch: got valid=%b pc=%h instr=%h want 1/100/00308293", if_id_valid, if_id_pc, if_id_instr);
    end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      errors++; $display("FAIL flush_over_stall: got valid=%b instr=%h want 0/%h", if_id_valid, if_id_instr, NOP);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL flush_idle_fetch: got req=%b addr=%h want 1/200", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align_addr: got %h want fffffffc", imem_addr); end
    imem_ready = 1'b1;
    step();  // grant 0xFFFFFFFC
    imem_ready = 1'b0;
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0040_8313;
    step();
    imem_rvalid = 1'b0;
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'd0 || if_id_instr !== 32'h0040_8313) begin
      errors++; $display("FAIL wrap_ifid: got pc=%h pc4=%h instr=%h want fffffffc/0/00408313", if_id_pc, if_id_pc4, if_id_instr);
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1; imem_ready = 1'b1;
    step();  // grant addr 0, IF/ID held under stall
    imem_ready = 1'b0;
    checks++; if (imem_addr !== 32'd4 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got addr=%h valid=%b want 4/1", imem_addr, if_id_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL async_req: got req=%b addr=%h want 0/0", imem_req, imem_addr);
    end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'd0 || if_id_pc4 !== 32'd4) begin
      errors++; $display("FAIL async_ifid: got valid=%b instr=%h pc=%h pc4=%h want 0/%h/0/4", if_id_valid, if_id_instr, if_id_pc, if_id_pc4, NOP);
    end
    step();
    rst = 1'b0; stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL after_async: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_ready_hold();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
